jtframe_rom_arb: RTL and testbench

- Shares the single SDRAM ROM read port among SLOTS game-side requesters, e.g. main CPU, sound CPU, char, scroll and object ROM fetchers.
- Port signals: sdram_req, sdram_addr, sdram_ack, data_rdy, data_read.
- Sits inside the game top, between the per-unit ROM fetchers and the frame's SDRAM controller.
- Sequences one read at a time, grants round-robin, drives refresh_en when idle, and stays off the port during download.

---
 rtl/jtframe_rom_arb_pkg.sv | 17 +
 rtl/jtframe_rr_pick.sv | 47 ++++
 rtl/jtframe_rom_arb.sv | 125 ++++++++++++
 tb/tb_jtframe_rom_arb.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_rom_arb_pkg.sv
// Shared types and helpers for the SDRAM ROM port arbiter.
package jtframe_rom_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    WAIT_RDY = 2'd2
  } arb_state_t;

  localparam int WDOG_W = 8;

  // Next slot index, wrapping back to 0 after slots-1.
  function automatic logic [2:0] wrap_inc(input logic [2:0] idx, input int slots);
    return (int'(idx) >= slots - 1) ? 3'd0 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/jtframe_rr_pick.sv
// Combinational round-robin picker: first requester after last_i wins.
// JTFRAME_ROMARB_PRIO0_EN: slot 0 always wins when requesting; the
// rotation then covers slots 1..SLOTS-1 only.
module jtframe_rr_pick
  import jtframe_rom_arb_pkg::*;
#(
  parameter int SLOTS = 4
) (
  input  logic [SLOTS-1:0] req_i,
  input  logic [2:0]       last_i,
  output logic             valid_o,
  output logic [2:0]       idx_o
);

  logic [7:0] req_pad;
  assign req_pad = 8'(req_i);

  // Scan forward from last_i+1; the first hit is kept.
  always_comb begin
    logic [2:0] cand;
    valid_o = 1'b0;
    idx_o   = 3'd0;
    cand    = last_i;
`ifdef JTFRAME_ROMARB_PRIO0_EN
    for (int k = 0; k < SLOTS - 1; k++) begin
      cand = (int'(cand) >= SLOTS - 1) ? 3'd1 : cand + 3'd1;
      if (!valid_o && req_pad[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
    if (req_pad[0]) begin
      valid_o = 1'b1;
      idx_o   = 3'd0;
    end
`else
    for (int k = 0; k < SLOTS; k++) begin
      cand = wrap_inc(cand, SLOTS);
      if (!valid_o && req_pad[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
`endif
  end

endmodule

// File: rtl/jtframe_rom_arb.sv
// SDRAM ROM read-port arbiter: one read at a time, round-robin grants,
// refresh allowed while idle, no grants during ROM download.
// Optional macro JTFRAME_ROMARB_PRIO0_EN gives slot 0 strict priority.
module jtframe_rom_arb
  import jtframe_rom_arb_pkg::*;
#(
  parameter int SLOTS = 4,
  parameter int AW    = 22,
  parameter int DW    = 32,
  parameter int TOUT  = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              downloading,
  input  logic [SLOTS-1:0]  slot_req,
  input  logic [SLOTS*AW-1:0] slot_addr,
  output logic [SLOTS-1:0]  slot_ok,
  output logic [DW-1:0]     slot_dout,
  output logic              sdram_req,
  output logic [AW-1:0]     sdram_addr,
  input  logic              sdram_ack,
  input  logic              data_rdy,
  input  logic [DW-1:0]     data_read,
  output logic              refresh_en,
  output logic [2:0]        sel
);

  localparam logic [WDOG_W-1:0] TOUT_W = WDOG_W'(TOUT);

  arb_state_t        state_q;
  logic [2:0]        sel_q, last_q, last_d;
  logic [AW-1:0]     addr_q;
  logic              req_q, refresh_q;
  logic [SLOTS-1:0]  ok_q;
  logic [DW-1:0]     dout_q;
  logic [WDOG_W-1:0] wdog_q;
  logic              pick_valid_d;
  logic [2:0]        pick_idx_d;

  jtframe_rr_pick #(.SLOTS(SLOTS)) u_pick (
    .req_i   (slot_req),
    .last_i  (last_q),
    .valid_o (pick_valid_d),
    .idx_o   (pick_idx_d)
  );

  // Pointer value after a completed read; slot 0 leaves it alone in priority mode.
  always_comb begin
    last_d = sel_q;
`ifdef JTFRAME_ROMARB_PRIO0_EN
    if (sel_q == 3'd0) last_d = last_q;
`endif
  end

  // Transaction sequencer with watchdog and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= 3'd0;
      last_q    <= 3'(SLOTS - 1);
      addr_q    <= '0;
      req_q     <= 1'b0;
      refresh_q <= 1'b1;
      ok_q      <= '0;
      dout_q    <= '0;
      wdog_q    <= '0;
    end else begin
      ok_q <= '0;
      case (state_q)
        IDLE: begin
          refresh_q <= 1'b1;
          if (!downloading && pick_valid_d) begin
            sel_q     <= pick_idx_d;
            addr_q    <= slot_addr[int'(pick_idx_d)*AW +: AW];
            req_q     <= 1'b1;
            refresh_q <= 1'b0;
            wdog_q    <= '0;
            state_q   <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          wdog_q <= wdog_q + 1'b1;
          if (wdog_q == TOUT_W) begin
            req_q     <= 1'b0;
            refresh_q <= 1'b1;
            state_q   <= IDLE;
          end else if (sdram_ack) begin
            req_q <= 1'b0;
            if (data_rdy) begin
              dout_q    <= data_read;
              ok_q      <= SLOTS'(1) << sel_q;
              last_q    <= last_d;
              refresh_q <= 1'b1;
              state_q   <= IDLE;
            end else begin
              state_q <= WAIT_RDY;
            end
          end
        end
        WAIT_RDY: begin
          wdog_q <= wdog_q + 1'b1;
          if (wdog_q == TOUT_W) begin
            refresh_q <= 1'b1;
            state_q   <= IDLE;
          end else if (data_rdy) begin
            dout_q    <= data_read;
            ok_q      <= SLOTS'(1) << sel_q;
            last_q    <= last_d;
            refresh_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign slot_ok    = ok_q;
  assign slot_dout  = dout_q;
  assign sdram_req  = req_q;
  assign sdram_addr = addr_q;
  assign refresh_en = refresh_q;
  assign sel        = sel_q;

endmodule

// File: tb/tb_jtframe_rom_arb.sv
module tb_jtframe_rom_arb;
  localparam int SLOTS = 4;
  localparam int AW    = 22;
  localparam int DW    = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              downloading = 1'b0;
  logic [SLOTS-1:0]  slot_req = '0;
  logic [SLOTS*AW-1:0] slot_addr = '0;
  logic [SLOTS-1:0]  slot_ok;
  logic [DW-1:0]     slot_dout;
  logic              sdram_req;
  logic [AW-1:0]     sdram_addr;
  logic              sdram_ack = 1'b0;
  logic              data_rdy = 1'b0;
  logic [DW-1:0]     data_read = '0;
  logic              refresh_en;
  logic [2:0]        sel;

  jtframe_rom_arb #(.SLOTS(SLOTS), .AW(AW), .DW(DW), .TOUT(255)) dut (
    .clk(clk), .rst(rst), .downloading(downloading),
    .slot_req(slot_req), .slot_addr(slot_addr),
    .slot_ok(slot_ok), .slot_dout(slot_dout),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr),
    .sdram_ack(sdram_ack), .data_rdy(data_rdy), .data_read(data_read),
    .refresh_en(refresh_en), .sel(sel)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [SLOTS-1:0] ok;
    logic [DW-1:0]    dout;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   ok_cnt[SLOTS];
  logic [AW-1:0] addr_tab[SLOTS];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every slot_ok pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && slot_ok != '0) begin
      for (int i = 0; i < SLOTS; i++) if (slot_ok[i]) ok_cnt[i]++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_ok: got slot_ok=%b, expected none", slot_ok);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (slot_ok !== e.ok || slot_dout !== e.dout) begin
          miscompares++;
          $display("FAIL slot_ok/dout: got %b/%h, expected %b/%h", slot_ok, slot_dout, e.ok, e.dout);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; slot_req = '0; downloading = 1'b0; sdram_ack = 1'b0; data_rdy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Acts as the SDRAM controller for one transaction; called at a negedge.
  task automatic do_txn(input int slot, input logic [DW-1:0] data, input bit same, input bit drop);
    int k;
    for (k = 0; k < 20 && !sdram_req; k++) @(negedge clk);
    check("grant_seen", 64'(sdram_req), 64'd1);
    check("grant_sel", 64'(sel), 64'(slot));
    check("grant_addr", 64'(sdram_addr), 64'(addr_tab[slot]));
    exp_q.push_back({4'(1 << slot), data});
    sdram_ack = 1'b1;
    if (same) begin
      data_rdy = 1'b1; data_read = data;
      @(negedge clk);
      sdram_ack = 1'b0; data_rdy = 1'b0;
      check("same_cycle_ok", 64'(slot_ok), 64'(1 << slot));
    end else begin
      @(negedge clk);
      sdram_ack = 1'b0;
      check("req_drop_on_ack", 64'(sdram_req), 64'd0);
      data_rdy = 1'b1; data_read = data;
      @(negedge clk);
      data_rdy = 1'b0;
      check("refresh_after_ok", 64'(refresh_en), 64'd1);
    end
    if (drop) slot_req[slot] = 1'b0;
  endtask

  initial begin
    int gap;
    addr_tab[0] = 22'h001234; addr_tab[1] = 22'h2B0002;
    addr_tab[2] = 22'h1C0001; addr_tab[3] = 22'h3A0003;
    for (int i = 0; i < SLOTS; i++) begin
      slot_addr[i*AW +: AW] = addr_tab[i];
      ok_cnt[i] = 0;
    end

    // reset values
    @(negedge clk);
    check("rst_sdram_req", 64'(sdram_req), 64'd0);
    check("rst_sdram_addr", 64'(sdram_addr), 64'd0);
    check("rst_slot_ok", 64'(slot_ok), 64'd0);
    check("rst_slot_dout", 64'(slot_dout), 64'd0);
    check("rst_refresh", 64'(refresh_en), 64'd1);
    check("rst_sel", 64'(sel), 64'd0);
    rst = 1'b0;

    // single read, one-cycle grant latency
    @(negedge clk);
    slot_req = 4'b0001;
    @(negedge clk);
    check("grant_latency", 64'(sdram_req), 64'd1);
    do_txn(0, 32'hDEADBEEF, 1'b0, 1'b1);

    // round-robin with all slots requesting
    do_reset();
    for (int i = 0; i < SLOTS; i++) ok_cnt[i] = 0;
    slot_req = 4'b1111;
    for (int t = 0; t < 8; t++) do_txn(t % 4, 32'hA0000000 + 32'(t), 1'b0, 1'b0);
    slot_req = '0;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < SLOTS; i++) check("rr_count", 64'(ok_cnt[i]), 64'd2);

    // ack and data in the same cycle
    do_reset();
    slot_req = 4'b0100;
    do_txn(2, 32'h13572468, 1'b1, 1'b1);

    // download blocks grants
    do_reset();
    downloading = 1'b1;
    slot_req = 4'b0110;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("dl_no_req", 64'(sdram_req), 64'd0);
      check("dl_refresh", 64'(refresh_en), 64'd1);
    end
    downloading = 1'b0;
    do_txn(1, 32'h11112222, 1'b0, 1'b1);
    do_txn(2, 32'h33334444, 1'b0, 1'b1);

    // watchdog: ack but never data
    do_reset();
    slot_req = 4'b0010;
    for (int k = 0; k < 20 && !sdram_req; k++) @(negedge clk);
    check("wd_first_grant", 64'(sdram_req), 64'd1);
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0;
    gap = 1;
    while (gap < 300 && !sdram_req) begin
      @(negedge clk);
      gap++;
      if (gap == 256) check("wd_refresh_idle", 64'(refresh_en), 64'd1);
    end
    check("wd_regrant_gap", 64'(gap), 64'd257);
    do_txn(1, 32'hCAFEF00D, 1'b0, 1'b1);

    // slot 0 priority (or pure round-robin without it)
    do_reset();
    slot_req = 4'b1110;
    do_txn(1, 32'h50000001, 1'b0, 1'b0);
    slot_req = 4'b1111;
`ifdef JTFRAME_ROMARB_PRIO0_EN
    do_txn(0, 32'h50000002, 1'b0, 1'b0);
    do_txn(0, 32'h50000003, 1'b0, 1'b0);
    do_txn(0, 32'h50000004, 1'b0, 1'b0);
    do_txn(0, 32'h50000005, 1'b0, 1'b0);
`else
    do_txn(2, 32'h50000002, 1'b0, 1'b0);
    do_txn(3, 32'h50000003, 1'b0, 1'b0);
    do_txn(0, 32'h50000004, 1'b0, 1'b0);
    do_txn(1, 32'h50000005, 1'b0, 1'b0);
`endif
    slot_req = '0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
